// File: rtl/bcd_display_scan_pkg.sv
// Shared constants and types for the multiplexed four-digit BCD display scanner.
package bcd_display_scan_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam int unsigned NUM_DIGITS = 4;
  localparam int unsigned NIBBLE_W   = 4;
  localparam int unsigned IDX_W      = 2;

  function automatic logic [NIBBLE_W-1:0] nibble_at(
    input logic [NUM_DIGITS*NIBBLE_W-1:0] v,
    input logic [IDX_W-1:0]               i
  );
    return v[{i, 2'b00} +: NIBBLE_W];
  endfunction

endpackage

// File: rtl/bcd_display_scan_slot_timer.sv
// Per-slot cycle counter; flags the last BLANK cycle and the last cycle of the slot.
module slot_timer #(
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  output logic blank_end,
  output logic slot_end
);

  localparam int unsigned CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [CW-1:0] cnt;

  // Slot changes always coincide with the counter's last value, so the wrap is the slot reset.
  always_ff @(posedge clk) begin
    if (rst || slot_end) cnt <= '0;
    else                 cnt <= cnt + CW'(1);
  end

  assign blank_end = (cnt == CW'(BLANK_CYCLES - 1));
  assign slot_end  = (cnt == CW'(PRESCALE - 1));

endmodule

// File: rtl/bcd_display_scan.sv
// Four-digit multiplexed display scanner with anti-ghost blanking, leading-zero
// suppression, invalid-digit suppression and frame-synchronous digit updates.
module bcd_display_scan
  import bcd_display_scan_pkg::*;
#(
  parameter int unsigned PRESCALE     = 50000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits,
  input  logic        lz_blank,
  output logic [3:0]  outBCD,
  output logic [3:0]  an,
  output logic        blank,
  output logic [1:0]  dig_idx,
  output logic        frame
);

  state_t        state, state_nx;
  logic          blank_end, slot_end, slot_chg, frame_edge;
  logic [15:0]   pending, disp;
  logic          seen, lz_q;
  logic [3:0]    nib;
  logic          upper_zero, suppress, show;

  slot_timer #(
    .PRESCALE    (PRESCALE),
    .BLANK_CYCLES(BLANK_CYCLES)
  ) u_slot_timer (
    .clk      (clk),
    .rst      (rst),
    .blank_end(blank_end),
    .slot_end (slot_end)
  );

  assign slot_chg   = (state == SHOW) && slot_end;
  assign frame_edge = slot_chg && (dig_idx == IDX_W'(NUM_DIGITS - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= BLANK;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      BLANK:   if (blank_end) state_nx = SHOW;
      SHOW:    if (slot_end)  state_nx = BLANK;
      default: state_nx = BLANK;
    endcase
  end

  // The frame edge is the clock edge entering slot 0; a load sampled on that same
  // edge bypasses pending so the new frame already shows it.
  always_ff @(posedge clk) begin
    if (rst) begin
      dig_idx <= '0;
      frame   <= 1'b0;
      pending <= '0;
      disp    <= '0;
      seen    <= 1'b0;
      lz_q    <= 1'b0;
    end else begin
      frame <= frame_edge;
      if (slot_chg) dig_idx <= dig_idx + 2'd1;
      if (load) pending <= digits;
      if (frame_edge) begin
        lz_q <= lz_blank;
        seen <= 1'b0;
        if (load)      disp <= digits;
        else if (seen) disp <= pending;
      end else if (load) begin
        seen <= 1'b1;
      end
    end
  end

  always_comb begin
    nib        = nibble_at(disp, dig_idx);
    upper_zero = ((disp >> {dig_idx, 2'b00}) == '0);
    suppress   = (nib > 4'd9) || (lz_q && (dig_idx != 2'd0) && upper_zero);
    show       = (state == SHOW) && !suppress;
    outBCD     = nib;
    an         = show ? ~(4'b0001 << dig_idx) : 4'hF;
    blank      = !show;
  end

endmodule

// File: tb/tb_bcd_display_scan.sv
// Scoreboard bench: each frame's per-cycle expected outputs are queued up front
// and popped one per clock as the scanner produces them.
module tb_bcd_display_scan;

  localparam int unsigned PS = 8;
  localparam int unsigned BC = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic        lz_blank = 1'b0;
  logic [15:0] digits = '0;
  logic [3:0]  outBCD, an;
  logic        blank, frame;
  logic [1:0]  dig_idx;

  typedef struct packed {
    logic [3:0] an;
    logic       blank;
    logic [3:0] bcd;
    logic [1:0] idx;
    logic       frame;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  bcd_display_scan #(
    .PRESCALE    (PS),
    .BLANK_CYCLES(BC)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .load    (load),
    .digits  (digits),
    .lz_blank(lz_blank),
    .outBCD  (outBCD),
    .an      (an),
    .blank   (blank),
    .dig_idx (dig_idx),
    .frame   (frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic void push_reset();
    exp_t e;
    e.an = 4'hF; e.blank = 1'b1; e.bcd = 4'h0; e.idx = 2'd0; e.frame = 1'b0;
    sbq.push_back(e);
  endfunction

  function automatic void push_frame(input logic [15:0] d, input logic lz, input logic fr);
    for (int s = 0; s < 4; s++) begin
      logic [3:0]  nib;
      logic [15:0] upper;
      logic        supp;
      exp_t        e;
      upper = d >> (4 * s);
      nib   = upper[3:0];
      supp  = (nib > 4'd9) || (lz && (s > 0) && (upper == 16'h0));
      for (int p = 0; p < int'(PS); p++) begin
        e.idx   = 2'(s);
        e.bcd   = nib;
        e.an    = ((p < int'(BC)) || supp) ? 4'hF : ~(4'b0001 << s);
        e.blank = (e.an == 4'hF);
        e.frame = fr && (s == 0) && (p == 0);
        sbq.push_back(e);
      end
    end
  endfunction

  task automatic tick(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_sb observed=empty expected=entry", tag);
    end else begin
      e = sbq.pop_front();
      chk({tag, "_an"},    an,             e.an);
      chk({tag, "_blank"}, {3'b0, blank},  {3'b0, e.blank});
      chk({tag, "_bcd"},   outBCD,         e.bcd);
      chk({tag, "_idx"},   {2'b0, dig_idx}, {2'b0, e.idx});
      chk({tag, "_frame"}, {3'b0, frame},  {3'b0, e.frame});
    end
  endtask

  // Runs n checked cycles; inputs driven after cycle c's check are sampled at its end.
  task automatic run(input string tag, input int n,
                     input int lc1, input logic [15:0] ld1,
                     input int lc2, input logic [15:0] ld2,
                     input int lzc, input logic lzv);
    for (int c = 0; c < n; c++) begin
      tick(tag);
      load = (c == lc1) || (c == lc2);
      if (c == lc1) digits = ld1;
      if (c == lc2) digits = ld2;
      if (c == lzc) lz_blank = lzv;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (5) push_reset();
    for (int i = 0; i < 5; i++) tick("reset");
    rst = 1'b0;

    // The last reset cycle doubles as cycle 0 of the first frame.
    push_frame(16'h0000, 1'b0, 1'b0);
    sbq.delete(0);
    run("frame0", 31, 9, 16'h1234, -1, 16'h0, -1, 1'b0);

    push_frame(16'h1234, 1'b0, 1'b1);
    run("scan", 32, 5, 16'h0070, -1, 16'h0, 4, 1'b1);

    push_frame(16'h0070, 1'b1, 1'b1);
    run("lzb", 32, 31, 16'h00A5, -1, 16'h0, 20, 1'b0);

    push_frame(16'h00A5, 1'b0, 1'b1);
    run("invalid", 32, 8, 16'h1111, 20, 16'h2222, -1, 1'b0);

    push_frame(16'h2222, 1'b0, 1'b1);
    run("tear", 32, -1, 16'h0, -1, 16'h0, -1, 1'b0);

    push_frame(16'h2222, 1'b0, 1'b1);
    run("hold", 21, 3, 16'h9999, -1, 16'h0, -1, 1'b0);
    load = 1'b0;
    rst  = 1'b1;
    sbq.delete();
    push_reset();
    tick("midrst");
    rst = 1'b0;

    push_frame(16'h0000, 1'b0, 1'b0);
    sbq.delete(0);
    run("restart", 31, -1, 16'h0, -1, 16'h0, -1, 1'b0);

    push_frame(16'h0000, 1'b0, 1'b1);
    run("discard", 32, -1, 16'h0, -1, 16'h0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
